// File: rtl/parking_gate_ctrl.sv
// Entry-barrier controller: admits or denies cars at the entry gate based on
// the upstream occupied-slot count, times out an unused opening, and
// publishes registered full / free-slot status and an admitted-car count.
module parking_gate_ctrl #(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned OPEN_CYCLES = 16,
  parameter int unsigned TMR_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] num,
  input  logic       entry_sensor,
  input  logic       pass_sensor,
  output logic       gate_open,
  output logic       full,
  output logic [3:0] free_slots,
  output logic       deny,
  output logic       timeout,
  output logic [7:0] entries
);

  localparam logic [3:0]       CAP      = 4'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic             entry_prev_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             gate_q, gate_d;
  logic             deny_q, deny_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       entries_q, entries_d;
  logic             full_q;
  logic [3:0]       free_q;

  logic lot_full;
  logic entry_rise;
  logic tmr_done;

  assign lot_full   = (num >= CAP);
  assign entry_rise = entry_sensor & ~entry_prev_q;
  assign tmr_done   = (timer_q == TMR_LAST);

  // Status path: full flag and saturated free-slot count, independent of the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      free_q <= CAP;
    end else begin
      full_q <= lot_full;
      free_q <= lot_full ? '0 : (CAP - num);
    end
  end

  // State register plus registered FSM outputs; entry_prev resets high so a
  // car already on the sensor at reset release must leave and return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      entry_prev_q <= 1'b1;
      timer_q      <= '0;
      gate_q       <= 1'b0;
      deny_q       <= 1'b0;
      timeout_q    <= 1'b0;
      entries_q    <= '0;
    end else begin
      state_q      <= state_d;
      entry_prev_q <= entry_sensor;
      timer_q      <= timer_d;
      gate_q       <= gate_d;
      deny_q       <= deny_d;
      timeout_q    <= timeout_d;
      entries_q    <= entries_d;
    end
  end

  // Next-state logic; pass takes priority over timer expiry in OPEN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (entry_rise) state_d = lot_full ? HOLD : OPEN;
      end
      OPEN: begin
        if (pass_sensor || tmr_done) state_d = HOLD;
      end
      HOLD: begin
        if (!entry_sensor) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values, registered on the following edge
  always_comb begin
    gate_d    = (state_d == OPEN);
    deny_d    = 1'b0;
    timeout_d = 1'b0;
    entries_d = entries_q;
    timer_d   = timer_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        deny_d  = entry_rise & lot_full;
      end
      OPEN: begin
        timer_d = timer_q + 1'b1;
        if (pass_sensor) entries_d = entries_q + 8'd1;
        else             timeout_d = tmr_done;
      end
      default: ;
    endcase
  end

  assign gate_open  = gate_q;
  assign deny       = deny_q;
  assign timeout    = timeout_q;
  assign entries    = entries_q;
  assign full       = full_q;
  assign free_slots = free_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: per-cycle vector table followed by
// hand-written sequences for timeout, pass-on-expiry and entries wrap.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] num;
  logic       entry_sensor;
  logic       pass_sensor;
  logic       gate_open;
  logic       full;
  logic [3:0] free_slots;
  logic       deny;
  logic       timeout;
  logic [7:0] entries;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  parking_gate_ctrl #(
    .CAPACITY   (8),
    .OPEN_CYCLES(16),
    .TMR_W      (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .num         (num),
    .entry_sensor(entry_sensor),
    .pass_sensor (pass_sensor),
    .gate_open   (gate_open),
    .full        (full),
    .free_slots  (free_slots),
    .deny        (deny),
    .timeout     (timeout),
    .entries     (entries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  num;
    logic        ent;
    logic        pas;
    logic [15:0] exp;  // {gate, full, free[3:0], deny, timeout, entries[7:0]}
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] n, input logic e, input logic p,
                     input logic g, input logic f, input logic [3:0] fr,
                     input logic d, input logic t, input logic [7:0] en);
    vec_t v;
    v.rst_n = r; v.num = n; v.ent = e; v.pas = p;
    v.exp = {g, f, fr, d, t, en};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {gate_open, full, free_slots, deny, timeout, entries};
  endfunction

  int gh;
  int tc;

  initial begin
    rst_n = 1'b0; num = '0; entry_sensor = 1'b0; pass_sensor = 1'b0;

    //   rst num ent pas | gate full free deny to entries
    // reset with car present; no trigger after release
    add(0, 0, 1, 0,   0, 0, 8, 0, 0, 0);
    add(0, 0, 1, 0,   0, 0, 8, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 8, 0, 0, 0);
    add(1, 3, 1, 0,   0, 0, 5, 0, 0, 0);
    add(1, 6, 1, 0,   0, 0, 2, 0, 0, 0);
    add(1, 8, 1, 0,   0, 1, 0, 0, 0, 0);
    add(1, 5, 0, 1,   0, 0, 3, 0, 0, 0);
    // admit; num change during OPEN ignored; pass closes gate
    add(1, 5, 1, 0,   1, 0, 3, 0, 0, 0);
    add(1, 9, 1, 0,   1, 1, 0, 0, 0, 0);
    add(1, 5, 1, 0,   1, 0, 3, 0, 0, 0);
    add(1, 5, 1, 1,   0, 0, 3, 0, 0, 1);
    add(1, 5, 1, 1,   0, 0, 3, 0, 0, 1);
    add(1, 5, 0, 0,   0, 0, 3, 0, 0, 1);
    // full: single deny pulse while car waits
    add(1, 8, 0, 0,   0, 1, 0, 0, 0, 1);
    add(1, 8, 1, 0,   0, 1, 0, 1, 0, 1);
    add(1, 8, 1, 0,   0, 1, 0, 0, 0, 1);
    add(1, 8, 1, 0,   0, 1, 0, 0, 0, 1);
    add(1, 3, 1, 0,   0, 0, 5, 0, 0, 1);
    add(1, 3, 0, 0,   0, 0, 5, 0, 0, 1);
    // out-of-range count treated as full
    add(1, 12, 0, 0,  0, 1, 0, 0, 0, 1);
    add(1, 12, 1, 0,  0, 1, 0, 1, 0, 1);
    add(1, 12, 0, 0,  0, 1, 0, 0, 0, 1);
    add(1, 15, 0, 0,  0, 1, 0, 0, 0, 1);
    // reset while OPEN closes gate on the same edge
    add(1, 0, 1, 0,   1, 0, 8, 0, 0, 1);
    add(0, 0, 1, 0,   0, 0, 8, 0, 0, 0);
    add(1, 0, 1, 0,   0, 0, 8, 0, 0, 0);
    add(1, 0, 0, 0,   0, 0, 8, 0, 0, 0);
    // boundary num = CAPACITY-1 still admits
    add(1, 7, 0, 0,   0, 0, 1, 0, 0, 0);
    add(1, 7, 1, 0,   1, 0, 1, 0, 0, 0);
    add(1, 7, 1, 1,   0, 0, 1, 0, 0, 1);
    add(1, 7, 0, 0,   0, 0, 1, 0, 0, 1);

    #1;
    for (int i = 0; i < vq.size(); i++) begin
      rst_n = vq[i].rst_n; num = vq[i].num;
      entry_sensor = vq[i].ent; pass_sensor = vq[i].pas;
      step();
      chk($sformatf("vec%0d", i), outs(), vq[i].exp);
    end

    // timeout: gate high exactly 16 cycles, one timeout pulse, entries unchanged
    num = 4'd2; entry_sensor = 1'b1; pass_sensor = 1'b0;
    gh = 0; tc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      gh += int'(gate_open);
      tc += int'(timeout);
    end
    chk("timeout_gate_cycles", 16'(gh), 16'd16);
    chk("timeout_pulses", 16'(tc), 16'd1);
    chk("timeout_entries", {8'h0, entries}, 16'd1);
    entry_sensor = 1'b0;
    step();

    // pass on the final open cycle: pass wins, no timeout
    entry_sensor = 1'b1;
    step();
    gh = int'(gate_open);
    tc = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      gh += int'(gate_open);
      tc += int'(timeout);
    end
    chk("expiry_gate_cycles", 16'(gh), 16'd16);
    pass_sensor = 1'b1;
    step();
    tc += int'(timeout);
    chk("expiry_gate_closed", {15'h0, gate_open}, 16'd0);
    chk("expiry_entries", {8'h0, entries}, 16'd2);
    pass_sensor = 1'b0;
    step();
    tc += int'(timeout);
    chk("expiry_no_timeout", 16'(tc), 16'd0);
    entry_sensor = 1'b0;
    step();

    // entries wrap: 255 admissions from reset, then one more
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; num = '0;
    step();
    for (int i = 0; i < 255; i++) begin
      entry_sensor = 1'b1; step();
      pass_sensor  = 1'b1; step();
      entry_sensor = 1'b0; pass_sensor = 1'b0; step();
    end
    chk("wrap_255", {8'h0, entries}, 16'd255);
    entry_sensor = 1'b1; step();
    pass_sensor  = 1'b1; step();
    entry_sensor = 1'b0; pass_sensor = 1'b0; step();
    chk("wrap_0", outs(), {1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
